// File: rtl/ivector_unfunnel_pkg.sv
// Shared IVectorRequest layout, sizing constants and unfunnel FSM encoding,
// used by both the funnel (transmit) and unfunnel (receive) sides.
package ivector_unfunnel_pkg;

    localparam int IVEC_DATA_WIDTH = 32;
    localparam int IVEC_WORDS      = 22;
    localparam int IVEC_MSG_WIDTH  = 704;

    // First funnel word lands in the most significant bits (field a).
    typedef struct packed {
        logic [31:0]       a;
        logic [15:0]       b;
        logic [15:0]       c;
        logic [19:0][31:0] vec;
    } ivector_request_t;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_DELIVER = 1'b1
    } unfunnel_state_e;

endpackage

// File: rtl/ivector_unfunnel_buffer.sv
// One message buffer: word-insert into a DATA_WIDTH*WORDS register plus its
// full flag. Data bits are deliberately left unreset.
module unfunnel_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 22,
    localparam int CW        = $clog2(WORDS)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        wr_en_i,
    input  logic [CW-1:0]               idx_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    input  logic                        complete_i,
    input  logic                        clear_i,
    output logic                        full_o,
    output logic [DATA_WIDTH*WORDS-1:0] msg_o
);

    logic [DATA_WIDTH*WORDS-1:0] data_q;
    logic                        full_q;

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < WORDS; k++) begin
            if (wr_en_i && (idx_i == CW'(k))) begin
                data_q[(WORDS-1-k)*DATA_WIDTH +: DATA_WIDTH] <= data_i;
            end
        end
    end

    // Writes are never offered to a full buffer, so set and clear cannot collide.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
        end else if (complete_i) begin
            full_q <= 1'b1;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign msg_o  = data_q;

endmodule

// File: rtl/ivector_unfunnel.sv
// Reassembles WORDS funnel words into one IVectorRequest message.
// Define IVECTOR_UNFUNNEL_PINGPONG_EN for two-buffer (ping-pong) operation.
module ivector_unfunnel
    import ivector_unfunnel_pkg::*;
#(
    parameter int DATA_WIDTH = IVEC_DATA_WIDTH,
    parameter int WORDS      = IVEC_WORDS
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        in_enq__ENA,
    input  logic [DATA_WIDTH-1:0]       in_enq_v,
    output logic                        in_enq__RDY,
    output logic                        ind_heard__ENA,
    output logic [DATA_WIDTH*WORDS-1:0] ind_heard_v,
    input  logic                        ind_heard__RDY
);

    localparam int MSG_W = DATA_WIDTH * WORDS;
    localparam int CW    = $clog2(WORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;
    logic          last_word;

    assign accept    = in_enq__ENA && in_enq__RDY;
    assign last_word = (cnt_q == LAST_IDX);

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = last_word ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef IVECTOR_UNFUNNEL_PINGPONG_EN
    logic             wsel_q, wsel_d;
    logic             rsel_q, rsel_d;
    logic [1:0]       full;
    logic [MSG_W-1:0] msg [2];

    for (genvar g = 0; g < 2; g++) begin : g_buf
        unfunnel_buffer #(
            .DATA_WIDTH(DATA_WIDTH),
            .WORDS     (WORDS)
        ) u_buf (
            .clk_i     (CLK),
            .rst_i     (RST),
            .wr_en_i   (accept && (wsel_q == 1'(g))),
            .idx_i     (cnt_q),
            .data_i    (in_enq_v),
            .complete_i(accept && last_word && (wsel_q == 1'(g))),
            .clear_i   (ind_heard__ENA && (rsel_q == 1'(g))),
            .full_o    (full[g]),
            .msg_o     (msg[g])
        );
    end

    assign in_enq__RDY    = !RST && !full[wsel_q];
    assign ind_heard__ENA = full[rsel_q] && ind_heard__RDY;
    assign ind_heard_v    = msg[rsel_q];

    assign wsel_d = wsel_q ^ (accept && last_word);
    assign rsel_d = rsel_q ^ ind_heard__ENA;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wsel_q <= 1'b0;
            rsel_q <= 1'b0;
        end else begin
            wsel_q <= wsel_d;
            rsel_q <= rsel_d;
        end
    end
`else
    unfunnel_state_e  state_q;
    logic             full;
    logic [MSG_W-1:0] msg;

    unfunnel_buffer #(
        .DATA_WIDTH(DATA_WIDTH),
        .WORDS     (WORDS)
    ) u_buf (
        .clk_i     (CLK),
        .rst_i     (RST),
        .wr_en_i   (accept),
        .idx_i     (cnt_q),
        .data_i    (in_enq_v),
        .complete_i(accept && last_word),
        .clear_i   (ind_heard__ENA),
        .full_o    (full),
        .msg_o     (msg)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_COLLECT;
        end else begin
            case (state_q)
                ST_COLLECT: if (accept && last_word) state_q <= ST_DELIVER;
                ST_DELIVER: if (ind_heard__ENA)      state_q <= ST_COLLECT;
                default:                             state_q <= ST_COLLECT;
            endcase
        end
    end

    // Gated by RST so the input side looks closed while reset is held.
    assign in_enq__RDY    = !RST && (state_q == ST_COLLECT);
    assign ind_heard__ENA = full && ind_heard__RDY;
    assign ind_heard_v    = msg;
`endif

endmodule
